// File: rtl/adc_pkg.sv
// Shared types and constants for the ADS7816-style serial ADC reader.
package adc_pkg;

  localparam int unsigned ADC_BITS     = 12;
  localparam int unsigned ADC_PERIODS  = 15;
  localparam int unsigned ADC_NULL_IDX = 2;
  localparam int unsigned ADC_MSB_IDX  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StClocking,
    StLatch,
    StGap
  } adc_state_e;

endpackage

// File: rtl/adc_sclk_gen.sv
// DCLOCK generator: half-period counter, registered serial clock, and single-cycle
// strobes on the last high cycle (fall_tick) and last low cycle (sample_tick) of each period.
module adc_sclk_gen #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic load_i,
  input  logic last_i,
  output logic dclk_o,
  output logic fall_tick_o,
  output logic sample_tick_o
);

  logic [15:0] half_q, half_d;
  logic        dclk_q, dclk_d;
  logic        half_end;

  assign half_end = (half_q == 16'(HALF_DIV - 1));
  assign dclk_o   = dclk_q;

  always_comb begin
    half_d        = '0;
    dclk_d        = 1'b0;
    fall_tick_o   = 1'b0;
    sample_tick_o = 1'b0;
    if (load_i) begin
      dclk_d = 1'b1;
    end else if (run_i) begin
      dclk_d = dclk_q;
      half_d = half_q + 16'd1;
      if (half_end) begin
        half_d = '0;
        if (dclk_q) begin
          fall_tick_o = 1'b1;
          dclk_d      = 1'b0;
        end else begin
          // The final low half leaves DCLOCK parked low instead of starting a 16th period.
          sample_tick_o = 1'b1;
          dclk_d        = ~last_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      half_q <= '0;
      dclk_q <= 1'b0;
    end else begin
      half_q <= half_d;
      dclk_q <= dclk_d;
    end
  end

endmodule

// File: rtl/adc_serial_reader.sv
// Serial read-back controller for a 12-bit ADS7816-style ADC.
// Optional null-bit check built when ADC_NULLBIT_CHK_EN is defined.
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int unsigned HALF_DIV = 2,
  parameter int unsigned CS_HIGH  = 4
) (
  input  logic                clk_X4,
  input  logic                rst,
  input  logic                enable,
  input  logic                DOUT_6,
  output logic                CS_5,
  output logic                DCLOCK_7,
  output logic [ADC_BITS-1:0] data,
  output logic                valid,
  output logic                busy,
  output logic                null_err
);

  adc_state_e          state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [ADC_BITS-1:0] shreg_q, shreg_d;
  logic                fell_q, fell_d;
  logic                cs_q, busy_q, valid_q;
  logic [ADC_BITS-1:0] data_q;
  logic                sclk_run, sclk_load, last_period;
  logic                fall_tick, sample_tick, take;

  assign last_period = (bit_q == 4'(ADC_PERIODS - 1));
  // Only sample once a real falling edge has been issued in this period.
  assign take        = sample_tick & fell_q;

  adc_sclk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_sclk_gen (
    .clk_i        (clk_X4),
    .rst_i        (rst),
    .run_i        (sclk_run),
    .load_i       (sclk_load),
    .last_i       (last_period),
    .dclk_o       (DCLOCK_7),
    .fall_tick_o  (fall_tick),
    .sample_tick_o(sample_tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    fell_d    = fell_q;
    sclk_run  = (state_q == StClocking);
    sclk_load = 1'b0;

    if (fall_tick) begin
      fell_d = 1'b1;
    end else if (sample_tick) begin
      fell_d = 1'b0;
    end

    if (take) begin
      if (bit_q >= 4'(ADC_MSB_IDX)) begin
        shreg_d = {shreg_q[ADC_BITS-2:0], DOUT_6};
      end
      if (!last_period) begin
        bit_d = bit_q + 4'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (cnt_q == 16'(HALF_DIV - 1)) begin
          sclk_load = 1'b1;
          state_d   = StClocking;
          cnt_d     = '0;
          bit_d     = '0;
          shreg_d   = '0;
          fell_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StClocking: begin
        if (take && last_period) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        state_d = StGap;
        cnt_d   = '0;
      end
      StGap: begin
        if (cnt_q == 16'(CS_HIGH - 1)) begin
          state_d = enable ? StSetup : StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge clk_X4) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      fell_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      fell_q  <= fell_d;
      cs_q    <= ~((state_d == StSetup) || (state_d == StClocking));
      busy_q  <= (state_d != StIdle);
      valid_q <= (state_d == StLatch);
      if (state_d == StLatch) begin
        data_q <= shreg_d;
      end
    end
  end

  assign CS_5  = cs_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign data  = data_q;

`ifdef ADC_NULLBIT_CHK_EN
  logic null_seen_q, null_err_q;

  always_ff @(posedge clk_X4) begin
    if (rst) begin
      null_seen_q <= 1'b0;
      null_err_q  <= 1'b0;
    end else begin
      if (state_q == StSetup) begin
        null_seen_q <= 1'b0;
      end else if (take && (bit_q == 4'(ADC_NULL_IDX)) && DOUT_6) begin
        null_seen_q <= 1'b1;
      end
      if ((state_d == StLatch) && null_seen_q) begin
        null_err_q <= 1'b1;
      end
    end
  end

  assign null_err = null_err_q;
`else
  assign null_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: default-parameter instance plus a HALF_DIV=1/CS_HIGH=1
// instance, each driven by a small behavioural ADS7816 model.
module tb_adc_serial_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_a = 1'b0;
  logic        enable_b = 1'b0;
  logic        dout_a = 1'b0;
  logic        dout_b = 1'b0;
  logic        cs_a, dclk_a, valid_a, busy_a, nerr_a;
  logic        cs_b, dclk_b, valid_b, busy_b, nerr_b;
  logic [11:0] data_a, data_b;

  logic [11:0] adc_word   = 12'hA5C;
  logic [11:0] adc_word_b = 12'hC3A;
  logic        null_a     = 1'b0;
  logic        alt_mode   = 1'b0;

`ifdef ADC_NULLBIT_CHK_EN
  localparam logic NE = 1'b1;
`else
  localparam logic NE = 1'b0;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int v_t[$];
  int v_d[$];
  int v_n[$];
  int rise_t[$];
  int cs_fall_t[$];
  int cs_rise_t[$];

  always #5 clk = ~clk;

  adc_serial_reader u_dut_a (
    .clk_X4  (clk),
    .rst     (rst),
    .enable  (enable_a),
    .DOUT_6  (dout_a),
    .CS_5    (cs_a),
    .DCLOCK_7(dclk_a),
    .data    (data_a),
    .valid   (valid_a),
    .busy    (busy_a),
    .null_err(nerr_a)
  );

  adc_serial_reader #(
    .HALF_DIV(1),
    .CS_HIGH (1)
  ) u_dut_b (
    .clk_X4  (clk),
    .rst     (rst),
    .enable  (enable_b),
    .DOUT_6  (dout_b),
    .CS_5    (cs_b),
    .DCLOCK_7(dclk_b),
    .data    (data_b),
    .valid   (valid_b),
    .busy    (busy_b),
    .null_err(nerr_b)
  );

  // ADC output for the period started by rising edge number rc (1-based).
  function automatic logic adc_bit(input int rc, input logic [11:0] w, input logic nb);
    int j;
    j = rc - 1;
    if (j < 2) return 1'b1;
    if (j == 2) return nb;
    return w[14-j];
  endfunction

  int   rc_a = 0, rc_b = 0, alt_cnt = 0;
  logic pd_a = 1'b0, pcs_a = 1'b1, pd_b = 1'b0;
  logic [11:0] word_a;

  always @(negedge clk) begin
    if (cs_a) rc_a = 0;
    else if (dclk_a && !pd_a) rc_a = rc_a + 1;
    if (!cs_a && pcs_a && alt_mode) alt_cnt = alt_cnt + 1;
    pd_a   = dclk_a;
    pcs_a  = cs_a;
    word_a = alt_mode ? (alt_cnt[0] ? 12'h000 : 12'hFFF) : adc_word;
    dout_a = adc_bit(rc_a, word_a, null_a);
  end

  always @(negedge clk) begin
    if (cs_b) rc_b = 0;
    else if (dclk_b && !pd_b) rc_b = rc_b + 1;
    pd_b   = dclk_b;
    dout_b = adc_bit(rc_b, adc_word_b, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Record strobes and edges for n cycles; index 0 is the current cycle.
  task automatic observe(input bit sel, input int n);
    logic cs, dclk, pcs, pdclk;
    v_t.delete(); v_d.delete(); v_n.delete();
    rise_t.delete(); cs_fall_t.delete(); cs_rise_t.delete();
    pcs   = sel ? cs_b : cs_a;
    pdclk = sel ? dclk_b : dclk_a;
    for (int i = 0; i < n; i++) begin
      cs   = sel ? cs_b : cs_a;
      dclk = sel ? dclk_b : dclk_a;
      if (sel ? valid_b : valid_a) begin
        v_t.push_back(i);
        v_d.push_back(int'(sel ? data_b : data_a));
        v_n.push_back(int'(sel ? nerr_b : nerr_a));
      end
      if (dclk && !pdclk) rise_t.push_back(i);
      if (!cs && pcs) cs_fall_t.push_back(i);
      if (cs && !pcs) cs_rise_t.push_back(i);
      pcs   = cs;
      pdclk = dclk;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy_a; i++) tick();
    check(tag, busy_a, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_cs", cs_a, 1'b1);
    check("rst_dclk", dclk_a, 1'b0);
    check("rst_data", data_a, 12'h000);
    check("rst_valid", valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_nerr", nerr_a, 1'b0);
    rst = 1'b0;
    tick();
    check("idle_cs", cs_a, 1'b1);

    // Nominal single frame.
    enable_a = 1'b1;
    tick();
    enable_a = 1'b0;
    check("nom_cs_fall", cs_a, 1'b0);
    check("nom_busy", busy_a, 1'b1);
    check("nom_setup_dclk", dclk_a, 1'b0);
    observe(1'b0, 70);
    check("nom_rises", rise_t.size(), 15);
    check("nom_first_rise", qget(rise_t, 0), 2);
    check("nom_valid_n", v_t.size(), 1);
    check("nom_valid_t", qget(v_t, 0), 62);
    check("nom_data", qget(v_d, 0), 32'hA5C);
    check("nom_cs_rise", qget(cs_rise_t, 0), 62);
    check("nom_no_refall", cs_fall_t.size(), 0);
    check("nom_idle", busy_a, 1'b0);

    // Continuous run alternating 000/FFF.
    alt_mode = 1'b1;
    enable_a = 1'b1;
    tick();
    observe(1'b0, 201);
    check("cont_valid_n", v_t.size(), 3);
    check("cont_t0", qget(v_t, 0), 62);
    check("cont_gap1", qget(v_t, 1) - qget(v_t, 0), 67);
    check("cont_gap2", qget(v_t, 2) - qget(v_t, 1), 67);
    check("cont_d0", qget(v_d, 0), 32'h000);
    check("cont_d1", qget(v_d, 1), 32'hFFF);
    check("cont_d2", qget(v_d, 2), 32'h000);
    check("cont_cs_high", qget(cs_fall_t, 0) - qget(cs_rise_t, 0), 5);
    enable_a = 1'b0;
    wait_idle("cont_idle", 100);
    alt_mode = 1'b0;

    // Enable dropped at k=5.
    adc_word = 12'h3C6;
    enable_a = 1'b1;
    tick();
    for (int i = 0; i < 22; i++) tick();
    enable_a = 1'b0;
    observe(1'b0, 60);
    check("drop_valid_n", v_t.size(), 1);
    check("drop_valid_t", qget(v_t, 0), 40);
    check("drop_data", qget(v_d, 0), 32'h3C6);
    check("drop_no_fall", cs_fall_t.size(), 0);
    check("drop_idle", busy_a, 1'b0);

    // Reset at k=8 with enable held.
    adc_word = 12'h5A3;
    enable_a = 1'b1;
    tick();
    for (int i = 0; i < 34; i++) tick();
    check("rmid_busy", busy_a, 1'b1);
    rst = 1'b1;
    tick();
    check("rmid_cs", cs_a, 1'b1);
    check("rmid_dclk", dclk_a, 1'b0);
    check("rmid_data", data_a, 12'h000);
    check("rmid_valid", valid_a, 1'b0);
    check("rmid_busy0", busy_a, 1'b0);
    rst = 1'b0;
    tick();
    check("rmid_restart", cs_a, 1'b0);
    observe(1'b0, 63);
    check("rmid_valid_t", qget(v_t, 0), 62);
    check("rmid_data2", qget(v_d, 0), 32'h5A3);
    enable_a = 1'b0;
    wait_idle("rmid_idle", 100);

    // Null-bit fault.
    check("null_pre", nerr_a, 1'b0);
    null_a   = 1'b1;
    adc_word = 12'h123;
    enable_a = 1'b1;
    tick();
    enable_a = 1'b0;
    observe(1'b0, 70);
    check("null_at_latch", qget(v_n, 0), 32'(NE));
    check("null_data", qget(v_d, 0), 32'h123);
    null_a = 1'b0;
    enable_a = 1'b1;
    tick();
    enable_a = 1'b0;
    observe(1'b0, 70);
    check("null_sticky", nerr_a, NE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("null_cleared", nerr_a, 1'b0);

    // HALF_DIV=1, CS_HIGH=1 instance.
    enable_b = 1'b1;
    tick();
    check("sw_cs_fall", cs_b, 1'b0);
    observe(1'b1, 66);
    enable_b = 1'b0;
    check("sw_dclk_period", qget(rise_t, 1) - qget(rise_t, 0), 2);
    check("sw_first_rise", qget(rise_t, 0), 1);
    check("sw_rises", rise_t.size(), 30);
    check("sw_valid_t", qget(v_t, 0), 31);
    check("sw_frame", qget(v_t, 1) - qget(v_t, 0), 33);
    check("sw_refall", qget(cs_fall_t, 0), 33);
    check("sw_data", qget(v_d, 0), 32'hC3A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
# adc_serial_reader

Serial read-back controller for a 12-bit ADS7816-style SPI-like ADC. It is the acquisition counterpart of the DAC7611P serial driver on the same board. The block generates chip-select and the serial clock from `clk_X4`, shifts in the conversion result MSB-first, and presents a parallel 12-bit sample with a one-cycle valid strobe. It sits between the ADC header pins and the sample-processing logic in the fabric.

## Interface
Parameters:
- `HALF_DIV`, default 2: `clk_X4` cycles per DCLOCK half-period. Legal minimum is 1.
- `CS_HIGH`, default 4: `clk_X4` cycles that CS is held high between frames, excluding the LATCH cycle. Legal minimum is 1.

Ports:
- `clk_X4`, in, 1: the only clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: level signal; while high, conversions run back-to-back.
- `DOUT_6`, in, 1: serial data from the ADC.
- `CS_5`, out, 1: ADC chip select, active low.
- `DCLOCK_7`, out, 1: ADC serial clock. Idles low.
- `data`, out, 12: last completed sample, held until the next one.
- `valid`, out, 1: one-cycle strobe when `data` updates.
- `busy`, out, 1: high in every state except IDLE.
- `null_err`, out, 1: null-bit error flag. See Configuration.

All outputs are registered. Reset values: `CS_5`=1, `DCLOCK_7`=0, `data`=12'h000, `valid`=0, `busy`=0, `null_err`=0.

## Operation
States are IDLE, SETUP, CLOCKING, LATCH and GAP.
- **IDLE**: `CS_5`=1 and `DCLOCK_7`=0. If `enable`=1, go to SETUP.
- **SETUP**: `CS_5`=0 and `DCLOCK_7`=0 for `HALF_DIV` cycles. This meets the CS-to-clock setup time. Then go to CLOCKING.
- **CLOCKING**: 15 DCLOCK periods, indexed k=0..14. Each period is `HALF_DIV` cycles with `DCLOCK_7` high, then `HALF_DIV` cycles low.
  - `DOUT_6` is sampled on the last `clk_X4` cycle of each low half. Call that sample j=k.
  - Samples j=0 and j=1 fall in the ADC sampling window and are discarded.
  - Sample j=2 is the null bit and is expected to be 0.
  - Samples j=3..14 shift into a 12-bit register MSB-first, so j=3 is B11 and j=14 is B0.
  - After the low half of period 14, go to LATCH.
- **LATCH**: one cycle. `data` takes the shift register, `valid`=1 and `CS_5`=1. Then go to GAP.
- **GAP**: `CS_5`=1 for `CS_HIGH` cycles. At the end of GAP, go to SETUP if `enable`=1, otherwise go to IDLE.

Boundary rules:
- Deasserting `enable` mid-frame does not abort the frame. The frame completes, LATCH fires, and the FSM returns to IDLE after GAP.
- `rst` in any state forces the reset values on the next edge. There is no partial `valid`, and the shift register and counters are cleared.
- `enable` is sampled only in IDLE and at the last GAP cycle.
- The bit counter is 4 bits and saturates at 14. It never wraps into a 16th period.

## Timing
With the defaults (`HALF_DIV`=2, `CS_HIGH`=4), counting the first `CS_5`-low cycle as t0:
- SETUP occupies t0..t0+1.
- CLOCKING occupies t0+2..t0+61.
- LATCH is at t0+62, where `valid`=1.
- GAP occupies t0+63..t0+66.
- The next `CS_5` falls at t0+67. Continuous throughput is one sample per 67 cycles.

General formulas:
- CS-low time = 31·`HALF_DIV`.
- Frame period = 31·`HALF_DIV` + 1 + `CS_HIGH`.
- `enable` rising in IDLE causes `CS_5` to fall on the following edge, a latency of 1 cycle.

## Configuration
`ADC_NULLBIT_CHK_EN` controls the null-bit check.
- **Defined**: sample j=2 is checked. If it reads 1, `null_err` is set in the LATCH cycle of that frame, and `data`/`valid` still update. `null_err` is sticky until `rst`.
- **Undefined**: the null bit is ignored, `null_err` is tied to 0, and no check logic is built.

## Structure
- **Shared package `adc_pkg`**:
  - State enumeration: IDLE, SETUP, CLOCKING, LATCH, GAP.
  - `ADC_BITS`=12.
  - `ADC_PERIODS`=15.
  - `ADC_NULL_IDX`=2.
  - `ADC_MSB_IDX`=3.
- **Sub-module `adc_sclk_gen`**: one natural sub-module. It holds the half-period counter and produces `DCLOCK_7` plus single-cycle `fall_tick` and `sample_tick` strobes. The top level keeps the FSM, the bit counter and the shift register.

## Test plan
- **Nominal sample**: ADC model returns 12'hA5C with null bit 0, `enable` pulsed high in IDLE. Required: `CS_5` falls 1 cycle later, exactly 15 DCLOCK rising edges occur, `data`=12'hA5C and `valid`=1 for one cycle at t0+62, then IDLE with `busy`=0.
- **Continuous run**: `enable` held high, model alternates 12'h000 and 12'hFFF. Required: `valid` pulses exactly 67 cycles apart, `data` alternates correctly, and `CS_5` is high for 5 cycles between frames.
- **Enable dropped mid-frame**: `enable` deasserted at k=5. Required: the frame completes with a correct `data` value, one `valid`, and the FSM returns to IDLE after GAP with no new CS fall.
- **Reset mid-frame**: `rst` asserted at k=8. Required: the next cycle has `CS_5`=1, `DCLOCK_7`=0, `data`=0, `valid`=0 and `busy`=0; with `enable` still high, the next frame starts cleanly after reset release.
- **Null-bit fault**: model drives the null bit as 1 with `ADC_NULLBIT_CHK_EN` defined. Required: `null_err`=1 at LATCH and it stays 1 until `rst`. With the macro undefined, `null_err` stays 0.
- **Parameter sweep**: `HALF_DIV`=1 and `CS_HIGH`=1. Required: the DCLOCK period is 2 cycles and the frame period is 33 cycles.
